// File: rtl/pipe_hazard_ctrl.sv
// Control-path pipeline registers with load-use stall, EX-resolved flush and EX operand forwarding.
// Optional saturating stall/flush counters are enabled by defining PIPE_HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
   parameter int RA_W  = 5,
   parameter int CNT_W = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [16:0]     CTRL_ID,
   input  logic            VALID_ID,
   input  logic [RA_W-1:0] RS1_ID,
   input  logic [RA_W-1:0] RS2_ID,
   input  logic [RA_W-1:0] RD_ID,
   input  logic            USE_RS1_ID,
   input  logic            USE_RS2_ID,
   input  logic            BR_TAKEN_EX,
   output logic [16:0]     CTRL_EX,
   output logic [16:0]     CTRL_MEM,
   output logic [16:0]     CTRL_WB,
   output logic [RA_W-1:0] RD_EX,
   output logic [RA_W-1:0] RD_MEM,
   output logic [RA_W-1:0] RD_WB,
   output logic            STALL,
   output logic            FLUSH_IFID,
   output logic [1:0]      FWD_A,
   output logic [1:0]      FWD_B
`ifdef PIPE_HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] STALL_CNT,
   output logic [CNT_W-1:0] FLUSH_CNT
`endif
);

   localparam logic [16:0] BUBBLE = 17'h00010;
   localparam int B_RF_WE   = 0;
   localparam int B_IS_LOAD = 9;

   logic [RA_W-1:0] rs1_ex_reg;
   logic [RA_W-1:0] rs2_ex_reg;
   logic            valid_ex_reg;
   logic            valid_mem_reg;
   logic            valid_wb_reg;
   logic            ld_use;
   logic            idex_take;
   logic            mem_can_fwd;
   logic            wb_can_fwd;

   // A load in EX whose result the ID instruction needs cannot be forwarded in time.
   always_comb begin
      ld_use = valid_ex_reg & CTRL_EX[B_IS_LOAD] & CTRL_EX[B_RF_WE] & (RD_EX != '0) & VALID_ID &
               ((USE_RS1_ID & (RS1_ID == RD_EX)) | (USE_RS2_ID & (RS2_ID == RD_EX)));
   end

   assign STALL      = ld_use & ~BR_TAKEN_EX;
   assign FLUSH_IFID = BR_TAKEN_EX;
   assign idex_take  = VALID_ID & ~STALL & ~BR_TAKEN_EX;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         CTRL_EX       <= BUBBLE;
         CTRL_MEM      <= BUBBLE;
         CTRL_WB       <= BUBBLE;
         RD_EX         <= '0;
         RD_MEM        <= '0;
         RD_WB         <= '0;
         rs1_ex_reg    <= '0;
         rs2_ex_reg    <= '0;
         valid_ex_reg  <= 1'b0;
         valid_mem_reg <= 1'b0;
         valid_wb_reg  <= 1'b0;
      end else begin
         if (idex_take) begin
            CTRL_EX      <= CTRL_ID;
            RD_EX        <= RD_ID;
            rs1_ex_reg   <= RS1_ID;
            rs2_ex_reg   <= RS2_ID;
            valid_ex_reg <= 1'b1;
         end else begin
            CTRL_EX      <= BUBBLE;
            RD_EX        <= '0;
            rs1_ex_reg   <= '0;
            rs2_ex_reg   <= '0;
            valid_ex_reg <= 1'b0;
         end
         CTRL_MEM      <= CTRL_EX;
         RD_MEM        <= RD_EX;
         valid_mem_reg <= valid_ex_reg;
         CTRL_WB       <= CTRL_MEM;
         RD_WB         <= RD_MEM;
         valid_wb_reg  <= valid_mem_reg;
      end
   end

   assign mem_can_fwd = valid_mem_reg & CTRL_MEM[B_RF_WE] & (RD_MEM != '0);
   assign wb_can_fwd  = valid_wb_reg & CTRL_WB[B_RF_WE] & (RD_WB != '0);

   // One forwarding mux per EX operand; the MEM stage holds the youngest producer and wins.
   for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic [RA_W-1:0] rs;
      logic [1:0]      sel;
      assign rs = (gi == 0) ? rs1_ex_reg : rs2_ex_reg;
      always_comb begin
         sel = 2'b00;
         if (mem_can_fwd && (RD_MEM == rs)) begin
            sel = 2'b01;
         end else if (wb_can_fwd && (RD_WB == rs)) begin
            sel = 2'b10;
         end
      end
   end

   assign FWD_A = g_fwd[0].sel;
   assign FWD_B = g_fwd[1].sel;

`ifdef PIPE_HAZARD_PERF_CNT_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         STALL_CNT <= '0;
         FLUSH_CNT <= '0;
      end else begin
         if (STALL && (STALL_CNT != '1)) begin
            STALL_CNT <= STALL_CNT + CNT_W'(1);
         end
         if (FLUSH_IFID && (FLUSH_CNT != '1)) begin
            FLUSH_CNT <= FLUSH_CNT + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Consumer end of the ID-stage control decoder. It takes the decoded control bundle and register indices from ID and carries them through the ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use hazards and inserts bubbles, flushes on taken branches and jumps resolved in EX, and generates operand-forwarding selects for the EX stage. It sits between the decoder and the datapath pipeline registers in the pipelined core top.

Parameters:
RA_W, 5, register-index width
CNT_W, 32, width of optional performance counters

Ports:
CLK  in  1  core clock, rising edge
RST  in  1  asynchronous, active-high reset
CTRL_ID  in  17  decoded bundle {ALUOp[3:0], ALUSrcA, ALUSrcB, isJump, isLoad, D_MEM_BE[3:0], D_MEM_WEN(active-low), D_MemRead, RWSrc[1:0], RF_WE} = bits [16:0]
VALID_ID  in  1  IF/ID holds a real instruction
RS1_ID, RS2_ID, RD_ID  in  RA_W each  register indices of the ID instruction
USE_RS1_ID, USE_RS2_ID  in  1 each  ID instruction reads rs1 / rs2
BR_TAKEN_EX  in  1  EX resolved a taken branch or a jump; redirect the PC
CTRL_EX, CTRL_MEM, CTRL_WB  out  17 each  registered bundle for each stage
RD_EX, RD_MEM, RD_WB  out  RA_W each  destination index per stage
STALL  out  1  hold PC and IF/ID this cycle
FLUSH_IFID  out  1  squash IF/ID this cycle
FWD_A, FWD_B  out  2 each  EX operand select: 00 = RF, 01 = EX/MEM result, 10 = MEM/WB result

Behaviour:
- BUBBLE constant = 17'h00010: all fields 0 except D_MEM_WEN = 1 (no write), so RF_WE = 0 and D_MemRead = 0.
- Reset (asynchronous, takes effect immediately):
  - CTRL_EX, CTRL_MEM and CTRL_WB go to BUBBLE.
  - All RD outputs and the internal RS1_EX/RS2_EX go to 0.
  - Valid bits go to 0.
  - The combinational outputs then evaluate to STALL = 0, FLUSH_IFID = 0, FWD_A = FWD_B = 00.
- Load-use hazard:
  - Definition: ld_use = CTRL_EX.isLoad & CTRL_EX.RF_WE & (RD_EX != 0) & VALID_ID & ((USE_RS1_ID & RS1_ID == RD_EX) | (USE_RS2_ID & RS2_ID == RD_EX)).
  - STALL = ld_use & ~BR_TAKEN_EX (combinational).
  - FLUSH_IFID = BR_TAKEN_EX (combinational).
- Clocked update on each rising CLK:
  - ID/EX takes BUBBLE when STALL, BR_TAKEN_EX or ~VALID_ID; otherwise it takes CTRL_ID, RD_ID, RS1_ID and RS2_ID.
  - EX/MEM always takes ID/EX. MEM/WB always takes EX/MEM. There is no back-pressure beyond ID.
- Stall and flush latency:
  - A load-use stall lasts exactly 1 cycle. The next cycle the load is in MEM, ld_use deasserts and the dependent instruction enters EX with FWD pointing at MEM/WB on the following cycle.
  - Flush penalty is 2 instructions: the IF/ID instruction is squashed by the datapath and the ID instruction becomes a bubble into EX.
- Forwarding (combinational, evaluated against RS1_EX and RS2_EX):
  - FWD_A = 01 if CTRL_MEM.RF_WE & RD_MEM != 0 & RD_MEM == RS1_EX.
  - Else FWD_A = 10 if CTRL_WB.RF_WE & RD_WB != 0 & RD_WB == RS1_EX.
  - Else FWD_A = 00. FWD_B is the same rule using RS2_EX.
  - MEM/WB priority: the MEM stage wins when both match (youngest producer).
  - Register x0 is never forwarded.
  - Bubbles never forward, because their RF_WE = 0.
- Simultaneous events:
  - BR_TAKEN_EX together with ld_use: the flush wins, STALL = 0, and ID/EX gets BUBBLE.
  - Reset asserted mid-stall or mid-flush: all state is cleared immediately, with no residual stall.
- No internal FSM beyond the three stage registers. STALL is never asserted on two consecutive cycles for the same load.

Optional Feature:
Macro: PIPE_HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs STALL_CNT [CNT_W-1:0] and FLUSH_CNT [CNT_W-1:0].
  - Each increments by 1 on every rising CLK where STALL or FLUSH_IFID respectively is high, and saturates at all-ones.
  - Both reset to 0 on RST.
- Undefined: the ports and counters are absent. The core behaviour is identical either way.

Test Plan:
1. Reset: assert RST mid-run with a load in EX -> CTRL_EX/MEM/WB = 17'h00010, RD_* = 0 and STALL = 0 while RST is high; the values hold after release with VALID_ID = 0.
2. ALU back-to-back: ADDI x5 then ADD x6,x5,x5 -> when the ADD is in EX, FWD_A = FWD_B = 01. Then SUB x7,x5,x0 two instructions after the ADDI -> FWD_A = 10 and FWD_B = 00 (x0 is not forwarded).
3. Load-use: LW x8 then ADD x9,x8,x1 -> STALL = 1 for exactly 1 cycle and CTRL_EX = BUBBLE on the next cycle. Then the ADD is in EX with FWD_A = 10 and FWD_B = 00.
4. Branch flush: taken BEQ in EX (BR_TAKEN_EX = 1) -> FLUSH_IFID = 1 and CTRL_EX = BUBBLE on the next cycle; the BEQ itself moves to CTRL_MEM unchanged.
5. Simultaneous events: JAL in EX with BR_TAKEN_EX = 1 while the ID instruction creates a load-use match -> STALL = 0, FLUSH_IFID = 1, and ID/EX receives a bubble.
6. With PIPE_HAZARD_PERF_CNT_EN defined: run scenario 3 followed by scenario 4 -> STALL_CNT = 1 and FLUSH_CNT = 1. Preload a counter to all-ones via force -> it holds at all-ones.
